// File: rtl/asrv32_header.vh
// Shared constants for the asrv32 fetch stage.
// ASRV32_FETCH_MISALIGN_EN is undefined by default (misaligned redirect fault disabled).
`ifndef ASRV32_HEADER_VH
`define ASRV32_HEADER_VH

localparam logic [31:0] ASRV32_NOP = 32'h0000_0013;

typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_FAULT = 2'd3
} fetch_state_e;

`endif

// File: rtl/asrv32_fetch.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, one-entry hold buffer on stall.
// Optional ASRV32_FETCH_MISALIGN_EN: misaligned redirect enters FAULT and raises o_misaligned.
module asrv32_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_inst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic        o_misaligned
);
`include "asrv32_header.vh"

    // Memory handshake: a word is transferred in any cycle with o_imem_req & i_imem_ack;
    // the ack always refers to the o_imem_addr of that same cycle, so a request may be abandoned.
    fetch_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  hold_inst_q, hold_inst_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic         hold_vld_q, hold_vld_d;
    logic         mis_q, mis_d;
    logic [31:0]  redirect_target;

    assign redirect_target = i_redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        hold_vld_d  = hold_vld_q;
        mis_d       = mis_q;

        if (i_redirect) begin
            // Redirect wins over stall and any same-cycle ack; the squashed word is never replayed.
            state_d    = FETCH_REQ;
            req_d      = 1'b1;
            addr_d     = redirect_target;
            valid_d    = 1'b0;
            hold_vld_d = 1'b0;
            mis_d      = 1'b0;
`ifdef ASRV32_FETCH_MISALIGN_EN
            if (i_redirect_pc[1:0] != 2'b00) begin
                state_d = FETCH_FAULT;
                req_d   = 1'b0;
                mis_d   = 1'b1;
                pc_d    = i_redirect_pc;
            end
`endif
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    state_d = FETCH_REQ;
                    req_d   = 1'b1;
                end
                FETCH_REQ: begin
                    if (i_imem_ack) begin
                        addr_d = addr_q + 32'd4;
                        if (i_stall) begin
                            hold_inst_d = i_imem_inst;
                            hold_pc_d   = addr_q;
                            hold_vld_d  = 1'b1;
                            req_d       = 1'b0;
                            state_d     = FETCH_HOLD;
                        end else begin
                            inst_d  = i_imem_inst;
                            pc_d    = addr_q;
                            valid_d = 1'b1;
                        end
                    end else if (!i_stall) begin
                        valid_d = 1'b0;
                    end
                end
                FETCH_HOLD: begin
                    if (!i_stall) begin
                        inst_d     = hold_inst_q;
                        pc_d       = hold_pc_q;
                        valid_d    = hold_vld_q;
                        hold_vld_d = 1'b0;
                        req_d      = 1'b1;
                        state_d    = FETCH_REQ;
                    end
                end
                default: begin
                    // FAULT: parked until the next redirect.
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= FETCH_IDLE;
            req_q       <= 1'b0;
            addr_q      <= PC_RESET;
            inst_q      <= ASRV32_NOP;
            pc_q        <= PC_RESET;
            valid_q     <= 1'b0;
            hold_inst_q <= ASRV32_NOP;
            hold_pc_q   <= PC_RESET;
            hold_vld_q  <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            hold_vld_q  <= hold_vld_d;
            mis_q       <= mis_d;
        end
    end

    assign o_imem_req  = req_q;
    assign o_imem_addr = addr_q;
    assign o_inst      = inst_q;
    assign o_pc        = pc_q;
    assign o_valid     = valid_q;
`ifdef ASRV32_FETCH_MISALIGN_EN
    assign o_misaligned = mis_q;
`else
    logic mis_unused;
    assign mis_unused   = mis_q;
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_asrv32_fetch.sv
// Directed bench for asrv32_fetch: sequential fetch, stall/hold, redirect, wrap, bubbles, misalign.
module tb_asrv32_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        misaligned;
    logic        ack_en;

    int tests_run;
    int tests_failed;

    asrv32_fetch #(.PC_RESET(32'h0000_0000)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_inst  (imem_inst),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .i_stall      (stall),
        .o_inst       (inst),
        .o_pc         (pc),
        .o_valid      (valid),
        .o_misaligned (misaligned)
    );

    // Clock and memory model: memory returns addr^KEY whenever enabled and requested.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_ack  = ack_en & imem_req;
        imem_inst = imem_addr ^ KEY;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] exp_pc, input logic exp_valid);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_valid});
        if (exp_valid) check({tag, ".inst"}, inst, exp_pc ^ KEY);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        ack_en       = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        stall        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.req",   {31'd0, imem_req}, 32'd0);
        check("rst.addr",  imem_addr, 32'h0);
        check("rst.inst",  inst, 32'h0000_0013);
        check("rst.pc",    pc, 32'h0);
        check("rst.valid", {31'd0, valid}, 32'd0);
        check("rst.mis",   {31'd0, misaligned}, 32'd0);

        // Sequential fetch
        rst_n  = 1'b1;
        ack_en = 1'b1;
        tick();
        check("first.req",  {31'd0, imem_req}, 32'd1);
        check("first.addr", imem_addr, 32'h0);
        check("first.valid", {31'd0, valid}, 32'd0);
        tick(); expect_out("seq0", 32'h0, 1'b1);
        tick(); expect_out("seq4", 32'h4, 1'b1);
        tick(); expect_out("seq8", 32'h8, 1'b1);
        tick(); expect_out("seqC", 32'hC, 1'b1);
        check("seq.addr", imem_addr, 32'h10);

        // Stall while 0x10 is acked
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall", 32'hC, 1'b1);
            check("stall.req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick(); expect_out("unstall", 32'h10, 1'b1);
        check("unstall.req",  {31'd0, imem_req}, 32'd1);
        check("unstall.addr", imem_addr, 32'h14);
        tick(); expect_out("seq14", 32'h14, 1'b1);
        check("pre_redir.addr", imem_addr, 32'h18);

        // Redirect with ack for 0x18 and stall in the same cycle
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        stall       = 1'b1;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("redir.valid", {31'd0, valid}, 32'd0);
        check("redir.addr",  imem_addr, 32'h200);
        tick(); expect_out("redir.first", 32'h200, 1'b1);

        // Wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        tick(); expect_out("wrap.top", 32'hFFFF_FFFC, 1'b1);
        tick(); expect_out("wrap.zero", 32'h0, 1'b1);
        check("wrap.addr4", imem_addr, 32'h4);

        // Ack withheld at 0x40
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bubble.addr",  imem_addr, 32'h40);
            check("bubble.valid", {31'd0, valid}, 32'd0);
            check("bubble.req",   {31'd0, imem_req}, 32'd1);
        end
        ack_en = 1'b1;
        tick(); expect_out("bubble.done", 32'h40, 1'b1);

        // Misaligned redirect
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef ASRV32_FETCH_MISALIGN_EN
        for (int i = 0; i < 2; i++) begin
            check("fault.mis",   {31'd0, misaligned}, 32'd1);
            check("fault.pc",    pc, 32'h102);
            check("fault.req",   {31'd0, imem_req}, 32'd0);
            check("fault.valid", {31'd0, valid}, 32'd0);
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("unfault.mis",  {31'd0, misaligned}, 32'd0);
        check("unfault.addr", imem_addr, 32'h100);
        tick(); expect_out("unfault.first", 32'h100, 1'b1);
`else
        check("misdis.mis",  {31'd0, misaligned}, 32'd0);
        check("misdis.addr", imem_addr, 32'h100);
        check("misdis.req",  {31'd0, imem_req}, 32'd1);
        tick(); expect_out("misdis.first", 32'h100, 1'b1);
        check("misdis.mis2", {31'd0, misaligned}, 32'd0);
`endif

        // Asynchronous reset while a request is outstanding
        check("areset.pre_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.req",   {31'd0, imem_req}, 32'd0);
        check("areset.valid", {31'd0, valid}, 32'd0);
        check("areset.addr",  imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
